// File: rtl/spi_flash_target.sv
// -----------------------------------------------------------------------------
// spi_flash_target
//
// Device side of a mode-0 SPI serial-flash link. The controller's cs_n/sck/mosi
// pins are synchronized into the system clock domain and oversampled. Two
// commands are understood:
//   0x03 READ     : 24-bit byte address, then data streamed from a 32-bit
//                   backing memory (little-endian bytes, each byte MSB first),
//                   continuing through consecutive words until cs_n rises.
//   0x9F JEDEC-ID : three ID bytes, MSB byte first, then zeros.
// Any other opcode raises a one-cycle bad_cmd pulse and is ignored to cs_n high.
//
// Ports
//   flash_clock_i  system clock, all logic on its rising edge
//   flash_reset_i  asynchronous active-high reset
//   flash_cs_n     chip select from controller (active low, asynchronous)
//   flash_sck      serial clock from controller (idle low)
//   flash_mosi     serial data in, taken on sck rise
//   flash_miso     serial data out, updated on sck fall
//   mem_req        one-cycle read strobe to the backing memory
//   mem_addr       word address, valid while mem_req is high
//   mem_rdata      read data, valid the cycle after mem_req
//   active         registered copy of synchronized ~cs_n
//   bad_cmd        one-cycle pulse when an unsupported opcode completes
// -----------------------------------------------------------------------------
module spi_flash_target #(
   parameter int unsigned ADDR_W      = 22,
   parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              flash_clock_i,
   input  logic              flash_reset_i,
   input  logic              flash_cs_n,
   input  logic              flash_sck,
   input  logic              flash_mosi,
   output logic              flash_miso,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rdata,
   output logic              active,
   output logic              bad_cmd
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_FETCH,   // mem_req is high this cycle
      ST_LOAD,    // mem_rdata valid this cycle
      ST_DATA,
      ST_ID,
      ST_IGNORE
   } state_e;

   // Synchronizer chains; the last stage is the usable, metastability-free copy.
   logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
   logic [SYNC_STAGES-1:0] sck_sync_q,  sck_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   sck_prev_q,  sck_prev_d;

   state_e              state_q,    state_d;
   logic [4:0]          bit_cnt_q,  bit_cnt_d;   // command/address bit count, or bit within byte
   logic [31:0]         sreg_q,     sreg_d;      // shift-in for opcode/address, shift-out for ID
   logic [31:0]         data_q,     data_d;      // word currently being sent
   logic [31:0]         buf_q,      buf_d;       // prefetched next word
   logic [1:0]          byte_ptr_q, byte_ptr_d;
   logic                rd_pend_q,  rd_pend_d;   // a read was strobed last cycle
   logic                miso_q,     miso_d;
   logic                mem_req_q,  mem_req_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic                active_q,   active_d;
   logic                bad_cmd_q,  bad_cmd_d;

   logic cs_s, sck_s, mosi_s, sck_rise, sck_fall;

   assign cs_s     = cs_sync_q[SYNC_STAGES-1];
   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
   assign sck_rise =  sck_s & ~sck_prev_q;
   assign sck_fall = ~sck_s &  sck_prev_q;

   always_comb begin
      // NOTE: every *_d gets a default before any branch, so no path leaves one
      // unassigned and no latch is inferred.
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   flash_cs_n};
      sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0],  flash_sck};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], flash_mosi};
      sck_prev_d  = sck_s;
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      sreg_d      = sreg_q;
      data_d      = data_q;
      buf_d       = buf_q;
      byte_ptr_d  = byte_ptr_q;
      rd_pend_d   = mem_req_q;
      miso_d      = miso_q;
      mem_req_d   = 1'b0;
      mem_addr_d  = mem_addr_q;
      active_d    = ~cs_s;
      bad_cmd_d   = 1'b0;

      if (state_q != ST_IDLE && cs_s) begin
         // Deselect wins over everything: partial bits and any in-flight or
         // prefetched word are simply abandoned.
         state_d = ST_IDLE;
         miso_d  = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               miso_d = 1'b0;
               // sck is not looked at here, so an edge coincident with the
               // select is never counted.
               if (!cs_s) begin
                  state_d   = ST_CMD;
                  bit_cnt_d = 5'd0;
               end
            end

            ST_CMD: begin
               if (sck_rise) begin
                  sreg_d    = {sreg_q[30:0], mosi_s};
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd7) begin
                     bit_cnt_d = 5'd0;
                     unique case ({sreg_q[6:0], mosi_s})
                        8'h03: state_d = ST_ADDR;
                        8'h9F: begin
                           state_d = ST_ID;
                           sreg_d  = {JEDEC_ID, 8'h00};
                        end
                        default: begin
                           state_d   = ST_IGNORE;
                           bad_cmd_d = 1'b1;
                        end
                     endcase
                  end
               end
            end

            ST_ADDR: begin
               if (sck_rise) begin
                  sreg_d    = {sreg_q[30:0], mosi_s};
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd23) begin
                     // Full byte address is {sreg_q[22:0], mosi_s}; its word
                     // part starts at bit 2, i.e. sreg_q bit 1.
                     state_d    = ST_FETCH;
                     mem_req_d  = 1'b1;
                     mem_addr_d = sreg_q[ADDR_W:1];
                     byte_ptr_d = {sreg_q[0], mosi_s};
                  end
               end
            end

            ST_FETCH: state_d = ST_LOAD;

            ST_LOAD: begin
               data_d    = mem_rdata;
               bit_cnt_d = 5'd0;
               state_d   = ST_DATA;
            end

            ST_DATA: begin
               if (rd_pend_q) begin
                  buf_d = mem_rdata;
               end
               if (sck_fall) begin
                  miso_d    = data_q[{byte_ptr_q, ~bit_cnt_q[2:0]}];
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  // Prefetch starts as the last byte of the word begins, giving
                  // a full byte time for the read to land in buf_q.
                  if (byte_ptr_q == 2'd3 && bit_cnt_q[2:0] == 3'd0) begin
                     mem_req_d  = 1'b1;
                     mem_addr_d = mem_addr_q + ADDR_W'(1);
                  end
                  if (bit_cnt_q[2:0] == 3'd7) begin
                     bit_cnt_d = 5'd0;
                     if (byte_ptr_q == 2'd3) begin
                        data_d     = buf_q;
                        byte_ptr_d = 2'd0;
                     end else begin
                        byte_ptr_d = byte_ptr_q + 2'd1;
                     end
                  end
               end
            end

            ST_ID: begin
               // Zeros shift in behind the ID, so miso idles low afterwards.
               if (sck_fall) begin
                  miso_d = sreg_q[31];
                  sreg_d = {sreg_q[30:0], 1'b0};
               end
            end

            ST_IGNORE: miso_d = 1'b0;

            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge flash_clock_i or posedge flash_reset_i) begin
      if (flash_reset_i) begin
         cs_sync_q   <= '1;
         sck_sync_q  <= '0;
         mosi_sync_q <= '0;
         sck_prev_q  <= 1'b0;
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 5'd0;
         sreg_q      <= 32'd0;
         data_q      <= 32'd0;
         buf_q       <= 32'd0;
         byte_ptr_q  <= 2'd0;
         rd_pend_q   <= 1'b0;
         miso_q      <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         active_q    <= 1'b0;
         bad_cmd_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         cs_sync_q   <= cs_sync_d;
         sck_sync_q  <= sck_sync_d;
         mosi_sync_q <= mosi_sync_d;
         sck_prev_q  <= sck_prev_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         sreg_q      <= sreg_d;
         data_q      <= data_d;
         buf_q       <= buf_d;
         byte_ptr_q  <= byte_ptr_d;
         rd_pend_q   <= rd_pend_d;
         miso_q      <= miso_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         active_q    <= active_d;
         bad_cmd_q   <= bad_cmd_d;
      end
   end

   assign flash_miso = miso_q;
   assign mem_req    = mem_req_q;
   assign mem_addr   = mem_addr_q;
   assign active     = active_q;
   assign bad_cmd    = bad_cmd_q;

endmodule

// File: doc/spi_flash_target.md
Name: spi_flash_target

Overview:
- SPI-mode-0 flash target (device side) of the serial flash link. Used as an on-chip flash model and as a flash-emulation endpoint.
- Samples the controller-driven cs_n/sck/mosi pins on the system clock.
- Decodes READ (0x03) and JEDEC-ID (0x9F) commands.
- For READ, fetches 32-bit words from a synchronous backing-memory read port and shifts the bytes out on miso.

Parameters:
- ADDR_W, 22, word-address width of the backing memory (byte address = {word, 2'b00}; upper byte-address bits beyond ADDR_W+2 ignored).
- JEDEC_ID, 24'hEF4016, 3-byte ID returned by 0x9F, MSB byte first.
- SYNC_STAGES, 2, synchronizer depth on flash_cs_n/flash_sck/flash_mosi (min 2).

Ports:
- flash_clock_i  in  1  system clock; all logic on posedge.
- flash_reset_i  in  1  asynchronous, active-high reset.
- flash_cs_n  in  1  chip select from controller, active low, asynchronous to clock.
- flash_sck  in  1  serial clock from controller, idle low (mode 0).
- flash_mosi  in  1  serial data in, sampled on sck rising edge.
- flash_miso  out  1  serial data out, changes after sck falling edge.
- mem_req  out  1  one-cycle read strobe to backing memory.
- mem_addr  out  ADDR_W  word address; valid while mem_req=1.
- mem_rdata  in  32  read data, valid exactly 1 cycle after mem_req.
- active  out  1  high while synchronized cs_n is low.
- bad_cmd  out  1  one-cycle pulse when an unsupported opcode completes.

Behaviour:
- Reset (async, any state): flash_miso=0, mem_req=0, mem_addr=0, active=0, bad_cmd=0, state=IDLE, synchronizers set to cs_n=1/sck=0/mosi=0.
- Input conditioning: each pin passes through SYNC_STAGES flops.
  - Rise/fall of sck is detected as sync vs. one-cycle-delayed sync.
  - Requirement on the controller: sck high and low phases each >= SYNC_STAGES+2 clock cycles. Faster sck is out of spec (undefined data, no hang).
- Shifting: bits are MSB-first. mosi is shifted in on detected rise. miso is updated on the cycle a fall is detected.
- States:
  - IDLE: miso=0. Synced cs_n falling -> CMD, bit counter=0.
  - CMD: after 8 rises, the opcode is complete.
    - 0x03 -> ADDR.
    - 0x9F -> ID, shift register loaded with JEDEC_ID.
    - Other -> IGNORE, bad_cmd pulses the cycle after the 8th rise.
  - ADDR: collect 24 bits. The cycle after the 24th rise: mem_req=1, mem_addr=addr[ADDR_W+1:2]. Next cycle: latch mem_rdata into the data word, byte pointer=addr[1:0] -> DATA.
  - DATA: the word is little-endian on the wire.
    - Byte k = mem_rdata[8k+7:8k]; each byte is sent MSB first.
    - First bit is driven on the first fall after the 24th address rise (fetch completes within SYNC_STAGES+2 cycles).
    - After byte 3's first bit is driven, prefetch: mem_req for word+1, modulo 2^ADDR_W (wraps to 0).
    - Prefetched word is held in a buffer and swapped in after byte 3's last bit, pointer=0.
    - Unaligned start: first word emits bytes addr[1:0]..3 only.
    - Read continues until cs_n rises.
  - ID: shift out 24 ID bits, then miso=0 until cs_n rises.
  - IGNORE: miso=0, ignore sck until cs_n rises.
- cs_n rising in any state (including mid-byte or mid-fetch) -> IDLE next cycle; miso=0; partial bits discarded. A fetch already in flight completes but its data is dropped. No pending prefetch survives.
- cs_n falling on the same cycle as an sck edge: the edge is ignored (counting starts on the next rise).
- active = ~synced cs_n, registered.
- Only one mem_req is outstanding at a time; mem_req is never high for two consecutive cycles.

Test Plan:
- Reset mid-DATA (flash_reset_i pulsed during byte 2) -> miso=0, mem_req=0, active=0 immediately. Next transaction 0x03 000000 works normally.
- READ aligned: cs low, send 03 00 00 10, memory word 4 = 32'h44332211, word 5 = 32'h88776655, clock 64 bits.
  - mem_req with mem_addr=4, then mem_addr=5.
  - miso bytes 11 22 33 44 55 66 77 88.
- READ unaligned plus wrap: ADDR_W=4, send 03 00 00 3E, word 15 = 32'hDDCCBBAA, word 0 = 32'h04030201.
  - miso CC DD 01 02.
  - Second mem_addr=0.
- JEDEC: send 9F, clock 32 bits -> miso EF 40 16 00.
- Bad opcode 0x05 -> bad_cmd pulses once after the 8th bit; miso stays 0 for 16 further bits; no mem_req.
- Abort: cs_n raised after 13 data bits, then a new READ of 03 00 00 00 -> first byte is word 0 byte 0; no residue from the aborted transfer.
